frame_loader: RTL and testbench

- Upstream stage of the 4-lane max comparator.
- Accepts a byte stream over a valid/ready handshake and packs 4 consecutive bytes into one frame.
- Presents the frame on 4 parallel 8-bit lanes for exactly one handoff.
- Lanes read zero whenever no frame is valid. The comparator ignores zero inputs, so idle cycles never disturb its running maximum.

---
 rtl/frame_loader_pkg.sv | 15 +
 rtl/frame_loader_idle_timer.sv | 27 ++
 rtl/frame_loader.sv | 107 ++++++++++
 tb/tb_frame_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_loader_pkg.sv
// Shared constants and types for the byte-to-frame loader feeding the 4-lane max comparator.
package frame_loader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LANES      = 4;
  localparam int CNT_W      = 16;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/frame_loader_idle_timer.sv
// Idle-cycle timer that closes a partial frame once the upstream has been quiet too long.
module frame_loader_idle_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] r_timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (clear) begin
      r_timer <= '0;
    end else if (run) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Fires on the idle cycle whose edge brings the count to TIMEOUT_CYC.
  assign expired = run && (r_timer == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/frame_loader.sv
// Packs 4 accepted bytes (or fewer, closed by in_last) into one frame for the max comparator.
// Optional partial-frame flush on idle is enabled with `define FRAME_LOADER_TIMEOUT_EN.
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef FRAME_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] lane_data_0,
  output logic [DATA_W-1:0] lane_data_1,
  output logic [DATA_W-1:0] lane_data_2,
  output logic [DATA_W-1:0] lane_data_3,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [CNT_W-1:0]  frame_count
);

  state_t            r_state;
  lane_idx_t         r_idx;
  logic [DATA_W-1:0] r_buf [LANES];
  logic [CNT_W-1:0]  r_frame_count;

  logic w_accept;
  logic w_close;
  logic w_handoff;
  logic w_timeout;

  assign in_ready    = (r_state == FILL);
  assign frame_valid = (r_state == HOLD);
  assign w_accept    = in_valid && in_ready;
  assign w_close     = w_accept && ((r_idx == lane_idx_t'(LANES - 1)) || in_last);
  assign w_handoff   = frame_valid && frame_ready;

`ifdef FRAME_LOADER_TIMEOUT_EN
  logic w_timer_clear;

  assign w_timer_clear = w_accept || (r_state == HOLD) || (r_idx == '0);

  frame_loader_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_timer_clear),
    .run     (!w_timer_clear),
    .expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: the 4-entry buffer is reset explicitly so lanes and padding are defined from the first frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= FILL;
      r_idx         <= '0;
      r_frame_count <= '0;
      for (int i = 0; i < LANES; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_buf[r_idx] <= in_data;
            if (w_close) begin
              for (int i = 0; i < LANES; i++)
                if (lane_idx_t'(i) > r_idx) r_buf[i] <= '0;
              r_idx   <= '0;
              r_state <= HOLD;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else if (w_timeout) begin
            // Unfilled slots start at r_idx on a flush.
            for (int i = 0; i < LANES; i++)
              if (lane_idx_t'(i) >= r_idx) r_buf[i] <= '0;
            r_idx   <= '0;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_handoff) begin
            for (int i = 0; i < LANES; i++) r_buf[i] <= '0;
            r_frame_count <= r_frame_count + 1'b1;
            r_state       <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  // Lanes are register outputs gated by state, so idle cycles present zeros to the comparator.
  assign lane_data_0 = frame_valid ? r_buf[0] : '0;
  assign lane_data_1 = frame_valid ? r_buf[1] : '0;
  assign lane_data_2 = frame_valid ? r_buf[2] : '0;
  assign lane_data_3 = frame_valid ? r_buf[3] : '0;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: expected frames queued at stimulus time, compared at handoff.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  lane_data_0, lane_data_1, lane_data_2, lane_data_3;
  logic        frame_valid;
  logic        frame_ready = 1'b1;
  logic [15:0] frame_count;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] sb [$];
  logic [15:0] exp_count = '0;

  always #5 clk = ~clk;

  frame_loader dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .lane_data_0 (lane_data_0),
    .lane_data_1 (lane_data_1),
    .lane_data_2 (lane_data_2),
    .lane_data_3 (lane_data_3),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_count (frame_count)
  );

  wire [31:0] lanes = {lane_data_0, lane_data_1, lane_data_2, lane_data_3};

  // Scoreboard: a handoff happens at the next rising edge whenever valid & ready hold at the falling edge.
  always @(negedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_frame: got lanes %h, none expected", lanes);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (lanes !== e) $display("FAIL frame_lanes: got %h expected %h", lanes, e);
        else passed++;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_wait: in_ready still %b after %0d cycles, expected 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({in_ready, frame_valid, lanes, frame_count} !== {1'b1, 1'b0, 32'h0, 16'h0})
      $display("FAIL reset_state: rdy=%b fv=%b lanes=%h cnt=%h, expected 1 0 0 0",
               in_ready, frame_valid, lanes, frame_count);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_frame;
    sb.push_back(32'h11223344);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    checks++;
    if ({frame_valid, in_ready} !== 2'b10)
      $display("FAIL full_hold: fv/rdy=%b expected 10", {frame_valid, in_ready});
    else passed++;
    step();
    exp_count++;
    checks++;
    if ({frame_valid, in_ready, lanes, frame_count} !== {2'b01, 32'h0, exp_count})
      $display("FAIL full_after: fv/rdy=%b lanes=%h cnt=%h expected 01 0 %h",
               {frame_valid, in_ready}, lanes, frame_count, exp_count);
    else passed++;
  endtask

  task automatic test_early_close;
    sb.push_back(32'h7F050000);
    send(8'h7F, 1'b0);
    send(8'h05, 1'b1);
    checks++;
    if (in_ready !== 1'b0) $display("FAIL early_ready_low: got %b expected 0", in_ready);
    else passed++;
    step();
    exp_count++;
    checks++;
    if ({in_ready, frame_valid, frame_count} !== {2'b10, exp_count})
      $display("FAIL early_ready_back: rdy/fv=%b cnt=%h expected 10 %h",
               {in_ready, frame_valid}, frame_count, exp_count);
    else passed++;
  endtask

  task automatic test_backpressure;
    int bad = 0;
    frame_ready = 1'b0;
    sb.push_back(32'hA0A1A2A3);
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({frame_valid, in_ready, lanes} !== {2'b10, 32'hA0A1A2A3}) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0 || frame_count !== exp_count)
      $display("FAIL bp_stall: %0d unstable cycles, cnt=%h expected 0 and %h", bad, frame_count, exp_count);
    else passed++;
    frame_ready = 1'b1;
    step();
    exp_count++;
    checks++;
    if ({frame_valid, frame_count} !== {1'b0, exp_count})
      $display("FAIL bp_release: fv=%b cnt=%h expected 0 %h", frame_valid, frame_count, exp_count);
    else passed++;
  endtask

  task automatic test_reset_mid_frame;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    reset = 1'b1;
    #2;
    exp_count = '0;
    checks++;
    if ({in_ready, frame_valid, lanes, frame_count} !== {2'b10, 32'h0, 16'h0})
      $display("FAIL mid_reset: rdy/fv=%b lanes=%h cnt=%h expected 10 0 0",
               {in_ready, frame_valid}, lanes, frame_count);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(32'h10111213);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0);
    step();
    exp_count++;
    checks++;
    if (frame_count !== exp_count) $display("FAIL mid_count: got %h expected %h", frame_count, exp_count);
    else passed++;
  endtask

  task automatic test_wrap_zeros;
    force dut.r_frame_count = 16'hFFFF;
    step();
    release dut.r_frame_count;
    exp_count = 16'hFFFF;
    checks++;
    if (frame_count !== exp_count) $display("FAIL wrap_preload: got %h expected %h", frame_count, exp_count);
    else passed++;
    sb.push_back(32'h00000009);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h09, 1'b0);
    step();
    exp_count++;
    checks++;
    if (frame_count !== 16'h0000 || exp_count !== 16'h0000)
      $display("FAIL wrap_count: got %h expected 0000", frame_count);
    else passed++;
  endtask

  task automatic test_timeout;
    int n = 0;
`ifdef FRAME_LOADER_TIMEOUT_EN
    sb.push_back(32'h3C000000);
    send(8'h3C, 1'b0);
    while (!frame_valid && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 16) $display("FAIL timeout_cycles: frame after %0d idle cycles, expected 16", n);
    else passed++;
    step();
    exp_count++;
`else
    sb.push_back(32'h3C3D0000);
    send(8'h3C, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step();
      if (frame_valid) n++;
    end
    checks++;
    if (n != 0 || in_ready !== 1'b1)
      $display("FAIL no_timeout: %0d frame-valid cycles rdy=%b, expected 0 and 1", n, in_ready);
    else passed++;
    send(8'h3D, 1'b1);
    step();
    exp_count++;
`endif
    checks++;
    if (frame_count !== exp_count) $display("FAIL timeout_count: got %h expected %h", frame_count, exp_count);
    else passed++;
  endtask

  task automatic test_back_to_back;
    sb.push_back(32'hC0C1C2C3);
    sb.push_back(32'hD0D1D2D3);
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i), 1'b0);
    step();
    exp_count += 2;
    checks++;
    if (frame_count !== exp_count) $display("FAIL b2b_count: got %h expected %h", frame_count, exp_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_early_close();
    test_backpressure();
    test_reset_mid_frame();
    test_wrap_zeros();
    test_timeout();
    test_back_to_back();
    repeat (5) step();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d frames never handed off, expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
